instr_fetch: RTL

Instruction fetch unit for the RV32 core: holds the fetch PC, issues word requests to instruction memory over a valid/ready request channel, buffers in-order responses in a small prefetch FIFO, and presents instructions with their PCs to `decode` over a valid/ready handshake. Redirects (taken branches, jumps, traps) come back from the PC-select logic. On a redirect the unit flushes buffered words, discards responses still in flight, and restarts at the new PC.

---
 rtl/instr_fetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: RV32 instruction fetch unit.
// Issues word requests to instruction memory under a credit rule so every
// response has a free prefetch slot. In-order responses are buffered in a
// small registered FIFO, and instructions are handed to decode with their PCs.
// A redirect flushes the FIFO, marks in-flight responses as stale, and restarts
// fetch at the target.
// Optional build macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect target halts fetch and raises fetch_fault until the next
// aligned redirect.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        fetch_fault
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   // Stale responses can pile up across back-to-back redirects against a slow
   // memory, so the drop counter gets headroom beyond one FIFO's worth.
   localparam int DROP_W = CNT_W + 4;
   localparam logic [CNT_W:0] DEPTH_V = FIFO_DEPTH[CNT_W:0];

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic [1:0] S_HALT = 2'd2;
`endif

   logic [1:0]        state, state_nxt;
   logic [31:0]       fetch_pc, head_pc;
   logic [CNT_W-1:0]  inflight, count;
   logic [DROP_W-1:0] drop_cnt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [31:0]       fifo_mem [FIFO_DEPTH];
   logic [31:0]       target;
   logic              fire, live_resp, push, pop;
   logic [CNT_W:0]    credit_used;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign;
   // The full target is kept so instr_pc can report the faulting address.
   assign target   = redirect_pc;
   assign misalign = |redirect_pc[1:0];
`else
   logic unused_pc_lo;
   // Fetch is word granular; the low target bits carry no information here.
   assign target       = {redirect_pc[31:2], 2'b00};
   assign unused_pc_lo = ^redirect_pc[1:0];
`endif

   // A response belongs to the live stream only once all stale ones are gone.
   assign live_resp   = imem_resp_valid && (drop_cnt == '0);
   assign instr_valid = (count != '0);
   // A redirect cancels both the push and the pop of its own cycle.
   assign push        = live_resp && !redirect_valid;
   assign pop         = instr_valid && instr_ready && !redirect_valid;

   // A slot freed by this cycle's pop is credited right away. The response to
   // a new request arrives one cycle later at the earliest, so the slot is
   // already free by then. This lets single-latency memory stream at full rate.
   assign credit_used    = {1'b0, inflight} + {1'b0, count} - {{CNT_W{1'b0}}, pop};
   assign imem_req_valid = (state == S_RUN) && !redirect_valid && (credit_used < DEPTH_V);
   assign fire           = imem_req_valid && imem_req_ready;
   assign imem_req_addr  = fetch_pc;

   assign instr    = fifo_mem[rd_ptr];
   assign instr_pc = head_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign fetch_fault = (state == S_HALT);
`else
   assign fetch_fault = 1'b0;
`endif

   // Next FSM state: IDLE lasts one cycle, and a redirect picks RUN or HALT.
   always_comb begin
      state_nxt = state;
      if (state == S_IDLE) state_nxt = S_RUN;
      if (redirect_valid) begin
         state_nxt = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (misalign) state_nxt = S_HALT;
`endif
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Fetch PC and head PC: a redirect wins, otherwise advance on fire and pop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         head_pc  <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= {target[31:2], 2'b00};
         head_pc  <= target;
      end else begin
         if (fire) fetch_pc <= fetch_pc + 32'd4;
         if (pop)  head_pc  <= head_pc + 32'd4;
      end
   end

   // Outstanding-request bookkeeping. On a redirect, every live request still
   // unanswered at the edge becomes stale. A response seen in the redirect
   // cycle belongs to the old stream.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         inflight <= '0;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         inflight <= '0;
         drop_cnt <= drop_cnt + DROP_W'(inflight) - DROP_W'(imem_resp_valid);
      end else begin
         inflight <= inflight + CNT_W'(fire) - CNT_W'(live_resp);
         if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
   end

   // FIFO pointers and occupancy. A redirect empties the FIFO.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FIFO storage. It is reset so that instr reads 0 until the first word lands.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else if (push) begin
         fifo_mem[wr_ptr] <= imem_resp_data;
      end
   end

endmodule
